if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: holds the PC and issues one instruction-memory request at a time.
- Accepts variable-latency responses and latches {pc, instr} into the IF/ID register that feeds ImmGen and the decoder.
- Supports load-use stall and branch-taken flush/redirect from the ID stage. The branch target is computed in ID from the ImmGen output.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word used for bubbles (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard unit: hold the IF/ID register and PC.
- flush_i  in  1  branch taken in ID: squash and redirect.
- branch_target_i  in  32  redirect PC, valid when flush_i=1.
- imem_req_o  out  1  request strobe, one cycle per request, always accepted.
- imem_addr_o  out  32  word address for the request.
- imem_rvalid_i  in  1  response valid, at least 1 cycle after request.
- imem_rdata_i  in  32  instruction word.
- id_valid_o  out  1  IF/ID entry valid.
- id_pc_o  out  32  PC of the IF/ID instruction.
- id_instr_o  out  32  instruction to decoder/ImmGen.

Behaviour:
- Reset (rst_i=1 at clock edge):
  - pc_q=RESET_PC, state=REQ, id_valid_o=0, id_pc_o=0, id_instr_o=NOP_INSTR.
  - imem_req_o=0 while rst_i is high.
  - Reset mid-operation abandons any outstanding request. A late rvalid arriving in REQ is ignored.
- Outputs from state:
  - imem_req_o=1 only in REQ (and rst_i=0).
  - imem_addr_o=pc_q, with bits [1:0] always 0.
- At most one request is outstanding. Throughput with a 1-cycle memory is 1 instruction per 2 cycles.
- FSM transitions (flush_i has priority over stall_i everywhere):
  - REQ: request issued this cycle. flush_i -> pc_q=target, go DROP; else go WAIT.
  - WAIT: see cases below.
    - rvalid & flush: discard data, pc_q=target, go REQ.
    - !rvalid & flush: pc_q=target, go DROP.
    - rvalid & !stall: load IF/ID, pc_q=pc_q+4, go REQ.
    - rvalid & stall: capture {pc_q, rdata} in hold buffer, go HOLD.
    - otherwise stay WAIT.
  - HOLD: flush -> drop buffer, pc_q=target, go REQ. !stall -> load IF/ID from buffer, pc_q+=4, go REQ. Otherwise stay.
  - DROP: the in-flight response is discarded. On rvalid go REQ. flush in DROP updates pc_q again.
- IF/ID register, per cycle, in priority order:
  - flush_i: valid=0, instr=NOP_INSTR, pc unchanged.
  - Else stall_i: hold all fields.
  - Else if an instruction is delivered (WAIT+rvalid or HOLD): valid=1, pc and instr loaded.
  - Else bubble: valid=0, instr=NOP_INSTR.
- Arithmetic:
  - PC increments modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
  - branch_target_i[1:0] is forced to 0 when loaded.
- Flush and rvalid in the same cycle: the response is always discarded, never loaded.
- Stall raised during WAIT/REQ does not block issue. It only affects delivery.

Decomposition:
- Package if_pkg:
  - state enum {REQ, WAIT, HOLD, DROP}.
  - NOP_INSTR constant.
  - default RESET_PC.
- Sub-module if_id_reg: pipeline latch with load/stall/flush priority and NOP bubble insertion.
- FSM, PC and hold buffer stay in the top module.

Test Plan:
1. Reset, 1-cycle memory returning 0x00500093 at 0, 0x00A00113 at 4 -> requests at addr 0, 4, 8 on every 2nd cycle; id_instr_o shows the two words with id_pc_o 0 and 4, valid=1 for one cycle each, bubbles (NOP, valid=0) between.
2. stall_i high for 3 cycles while response for addr 8 arrives -> HOLD entered; IF/ID unchanged during stall; addr-8 instruction delivered the cycle after stall drops; next request addr 12.
3. flush_i with target 0x40 while request for addr 12 is outstanding (latency 3) -> id_valid_o=0/NOP next cycle; stale response discarded; next request addr 0x40, delivered pc 0x40.
4. flush_i and stall_i asserted together with rvalid -> flush wins; IF/ID becomes NOP/invalid; data dropped; next request at target.
5. RESET_PC=32'hFFFF_FFFC -> first delivery pc 0xFFFFFFFC, next request addr 0x00000000; target 0x103 -> request addr 0x100.
6. rst_i asserted in WAIT, response arrives 2 cycles later -> outputs at reset values, response ignored, first post-reset request addr RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_e;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage_id_reg.sv
// IF/ID pipeline latch: flush beats stall beats load; otherwise a NOP bubble.
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic [31:0] load_instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = load_pc_i;
      instr_d = load_instr_i;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem request FSM and stall hold buffer,
// feeding the IF/ID latch.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IF_RESET_PC,
  parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [31:0]        branch_target_i,
  if_fetch_stage_if.master   imem,
  output logic               id_valid_o,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_instr_o
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic [31:0] target;

  assign target = word_align(branch_target_i);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load         = 1'b0;
    load_pc      = pc_q;
    load_instr   = imem.rdata;
    unique case (state_q)
      REQ: begin
        if (flush_i) begin
          pc_d    = target;
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush_i) begin
          // a response landing with the flush is stale and never delivered
          pc_d    = target;
          state_d = imem.rvalid ? REQ : DROP;
        end else if (imem.rvalid) begin
          if (stall_i) begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem.rdata;
            state_d      = HOLD;
          end else begin
            load    = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
        end
      end
      HOLD: begin
        if (flush_i) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall_i) begin
          load       = 1'b1;
          load_pc    = hold_pc_q;
          load_instr = hold_instr_q;
          pc_d       = pc_q + 32'd4;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (flush_i) pc_d = target;
        if (imem.rvalid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= REQ;
      pc_q         <= word_align(RESET_PC);
      hold_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem.req  = (state_q == REQ) && !rst_i;
  assign imem.addr = word_align(pc_q);

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .load_i       (load),
    .load_pc_i    (load_pc),
    .load_instr_i (load_instr),
    .valid_o      (id_valid_o),
    .pc_o         (id_pc_o),
    .instr_o      (id_instr_o)
  );

endmodule
